// File: rtl/lpf_channel_scheduler.sv
// Round-robin scheduler sharing one moving-average filter datapath between several
// channels: grant, issue to the filter, wait out its latency, return the tagged result.
module lpf_channel_scheduler #(
    parameter int data_width     = 16,
    parameter int num_channels   = 2,
    parameter int chan_bits      = 1,
    parameter int filter_latency = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [num_channels-1:0]            in_valid,
    input  logic [num_channels*data_width-1:0] in_data,
    output logic [num_channels-1:0]            in_ready,
    output logic                               filt_enable,
    output logic [data_width-1:0]              filt_sample_in,
    output logic [chan_bits-1:0]               filt_chan,
    input  logic [data_width-1:0]              filt_sample_out,
    output logic                               out_valid,
    output logic [chan_bits-1:0]               out_chan,
    output logic [data_width-1:0]              out_data,
    output logic                               busy
);
    localparam int cnt_bits = $clog2(filter_latency + 1);
    localparam logic [chan_bits-1:0] last_chan = chan_bits'(num_channels - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

    state_t                state;
    logic [chan_bits-1:0]  rr_ptr;
    logic [chan_bits-1:0]  grant_chan;
    logic [data_width-1:0] grant_data;
    logic                  grant_found;
    logic                  accept;
    logic [cnt_bits-1:0]   wait_cnt;
    int                    cand;

    // Search from rr_ptr upward with wrap; the first pending channel wins.
    always_comb begin
        grant_found = 1'b0;
        grant_chan  = '0;
        grant_data  = '0;
        in_ready    = '0;
        cand        = 0;
        for (int k = 0; k < num_channels; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= num_channels) begin
                cand = cand - num_channels;
            end
            for (int i = 0; i < num_channels; i++) begin
                if (!grant_found && (i == cand) && in_valid[i]) begin
                    grant_found = 1'b1;
                    grant_chan  = chan_bits'(i);
                    grant_data  = in_data[i*data_width +: data_width];
                    if (state == IDLE && !reset) begin
                        in_ready[i] = 1'b1;
                    end
                end
            end
        end
    end

    assign accept = |in_ready;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            wait_cnt       <= '0;
            filt_enable    <= 1'b0;
            filt_sample_in <= '0;
            filt_chan      <= '0;
            out_valid      <= 1'b0;
            out_chan       <= '0;
            out_data       <= '0;
        end else begin
            filt_enable <= 1'b0;
            out_valid   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        filt_sample_in <= grant_data;
                        filt_chan      <= grant_chan;
                        filt_enable    <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= cnt_bits'(filter_latency);
                    state    <= WAIT;
                end
                WAIT: begin
                    // The filter result is valid in the cycle the count shows 1.
                    if (wait_cnt == cnt_bits'(1)) begin
                        out_data  <= filt_sample_out;
                        out_chan  <= filt_chan;
                        out_valid <= 1'b1;
                        state     <= CAPTURE;
                    end else begin
                        wait_cnt <= wait_cnt - cnt_bits'(1);
                    end
                end
                CAPTURE: begin
                    rr_ptr <= (filt_chan == last_chan) ? '0 : filt_chan + chan_bits'(1);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lpf_channel_scheduler.sv
// Scoreboard bench for lpf_channel_scheduler: two instances (filter latency 1 and 3) driven by
// directed and random channel traffic, checked against a transaction-timeline reference model.
module tb_lpf_channel_scheduler;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    typedef struct {
        int          ch;
        logic [15:0] d;
        int          due;
    } item_t;

    task automatic chk(input int lat, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL L=%0d %s: got %h, required %h", lat, name, act, req);
    endtask

    task automatic timeout_fail(input int lat, input string what);
        checks++;
        $display("FAIL L=%0d %s: bound expired, got timeout, required completion", lat, what);
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int L = (g == 0) ? 1 : 3;

        logic        reset;
        logic [1:0]  in_valid;
        logic [1:0]  in_ready;
        logic [31:0] in_data;
        logic        filt_enable;
        logic [15:0] filt_sample_in;
        logic        filt_chan;
        logic [15:0] filt_sample_out;
        logic        out_valid;
        logic        out_chan;
        logic [15:0] out_data;
        logic        busy;

        lpf_channel_scheduler #(
            .data_width(16), .num_channels(2), .chan_bits(1), .filter_latency(L)
        ) dut (
            .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
            .in_ready(in_ready), .filt_enable(filt_enable), .filt_sample_in(filt_sample_in),
            .filt_chan(filt_chan), .filt_sample_out(filt_sample_out), .out_valid(out_valid),
            .out_chan(out_chan), .out_data(out_data), .busy(busy)
        );

        // Filter stand-in: input+1, valid only exactly L cycles after the enable cycle.
        int          age  = 1000;
        logic [15:0] fval = '0;
        always @(posedge clk) begin
            if (filt_enable) begin
                age  <= 1;
                fval <= filt_sample_in + 16'd1;
            end else if (age < 1000) begin
                age <= age + 1;
            end
        end
        assign filt_sample_out = (age == L) ? fval : 16'hDEAD;

        int          cyc     = 0;
        int          idle_at = 0;
        int          acc_t   = -100;
        int          ptr     = 0;
        int          n_acc   = 0;
        bit          armed   = 0;
        bit          prev_rst = 0;
        bit          fin     = 0;
        logic [1:0]  hs_last = '0;
        logic [1:0]  keep    = '0;
        logic        exp_ch  = 1'b0;
        logic [15:0] exp_smp = '0;
        logic [15:0] exp_out = '0;
        item_t       q[$];

        always @(negedge clk) begin
            logic [1:0] er;
            item_t      it;
            er = '0;
            if (!reset && cyc >= idle_at) begin
                for (int k = 0; k < 2; k++) begin
                    if (er == 2'b00 && in_valid[(ptr + k) % 2]) er[(ptr + k) % 2] = 1'b1;
                end
            end
            chk(L, "in_ready", in_ready, er);
            if (armed) begin
                chk(L, "busy", busy, (cyc > acc_t && cyc < idle_at));
                chk(L, "filt_enable", filt_enable, (cyc == acc_t + 1));
                if (cyc > acc_t && cyc < idle_at) begin
                    chk(L, "filt_chan", filt_chan, exp_ch);
                    chk(L, "filt_sample_in", filt_sample_in, exp_smp);
                end
                if (prev_rst) begin
                    chk(L, "reset filt_chan", filt_chan, 0);
                    chk(L, "reset filt_sample_in", filt_sample_in, 0);
                    chk(L, "reset out_chan", out_chan, 0);
                end
                if (out_valid) begin
                    if (q.size() == 0) begin
                        chk(L, "out_valid unexpected", out_valid, 0);
                    end else begin
                        it = q.pop_front();
                        chk(L, "out_chan", out_chan, it.ch);
                        chk(L, "out_data", out_data, it.d);
                        chk(L, "out_cycle", cyc, it.due);
                        exp_out = it.d;
                    end
                end else begin
                    chk(L, "out_data hold", out_data, exp_out);
                    if (q.size() > 0 && q[0].due < cyc) begin
                        chk(L, "out_valid missing at cycle", cyc, q[0].due);
                        void'(q.pop_front());
                    end
                end
            end
            hs_last = in_valid & in_ready;
            if (reset) begin
                q.delete();
                idle_at = cyc + 1;
                ptr     = 0;
                exp_out = '0;
                armed   = 1;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (hs_last[i]) begin
                        it.ch   = i;
                        it.d    = in_data[i*16 +: 16] + 16'd1;
                        it.due  = cyc + 2 + L;
                        q.push_back(it);
                        acc_t   = cyc;
                        idle_at = cyc + L + 3;
                        ptr     = (i + 1) % 2;
                        exp_ch  = 1'(i);
                        exp_smp = in_data[i*16 +: 16];
                        n_acc++;
                    end
                end
            end
            prev_rst = reset;
            cyc++;
        end

        task automatic step();
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (hs_last[i] && !keep[i]) in_valid[i] = 1'b0;
            end
        endtask

        task automatic drain();
            int n = 0;
            while ((in_valid != 2'b00 || cyc < idle_at || q.size() != 0) && n < 300) begin
                step();
                n++;
            end
            if (n >= 300) timeout_fail(L, "drain");
        endtask

        task automatic wait_acc(input int target);
            int n = 0;
            while (n_acc < target && n < 200) begin
                step();
                n++;
            end
            if (n_acc < target) timeout_fail(L, "accept");
        endtask

        initial begin
            reset    = 1'b1;
            in_valid = 2'b11;
            in_data  = {16'h0200, 16'h0100};
            repeat (3) step();
            reset = 1'b0;
            drain();

            in_data[15:0] = 16'h1234;
            in_valid      = 2'b01;
            drain();

            in_data  = {16'h0200, 16'h0100};
            keep     = 2'b11;
            in_valid = 2'b11;
            wait_acc(n_acc + 4);
            keep = 2'b00;
            drain();

            in_data[15:0] = 16'h5555;
            in_valid      = 2'b01;
            wait_acc(n_acc + 1);
            step();
            in_data[31:16] = 16'hBEEF;
            in_valid[1]    = 1'b1;
            drain();

            repeat (400) begin
                step();
                for (int i = 0; i < 2; i++) begin
                    if (!in_valid[i]) begin
                        if ($urandom_range(2) == 0) begin
                            in_data[i*16 +: 16] = 16'($urandom);
                            in_valid[i] = 1'b1;
                        end
                    end else if ($urandom_range(15) == 0) begin
                        in_valid[i] = 1'b0;
                    end
                end
            end
            drain();

            in_data[15:0] = 16'($urandom);
            in_valid      = 2'b01;
            wait_acc(n_acc + 1);
            step();
            reset = 1'b1;
            step();
            reset = 1'b0;
            in_data[31:16] = 16'($urandom);
            in_valid       = 2'b10;
            drain();

            repeat (5) step();
            fin = 1;
        end
    end

    initial begin
        int n;
        n = 0;
        while (!(inst[0].fin && inst[1].fin) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 20000) begin
            $display("FAIL global_timeout: got %0d cycles, required completion", n);
            $fatal(1, "bench did not complete");
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/lpf_channel_scheduler.md
Name: lpf_channel_scheduler

Overview:
- Time-multiplexes one moving-average low-pass filter datapath between `num_channels` audio channels (e.g. L/R).
- Accepts samples per channel with a valid/ready handshake and grants channels round-robin.
- Drives the filter's `enable` / `sample_in` plus a bank select, waits the filter latency, then returns the filtered result tagged with its channel.
- Sits between the sample-capture front end and the playback/DSP back end.

Parameters:
- data_width, 16, sample width in bits (matches filter data_width).
- num_channels, 2, number of requesting channels (>=2).
- chan_bits, 1, width of channel index; must satisfy 2**chan_bits >= num_channels.
- filter_latency, 1, cycles from the filter enable cycle until sample_out is valid (>=1).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  num_channels  bit i: channel i has a sample pending.
- in_data  input  num_channels*data_width  channel i sample at bits [i*data_width +: data_width].
- in_ready  output  num_channels  one-hot; bit i high = channel i sample accepted this cycle.
- filt_enable  output  1  one-cycle strobe to the filter.
- filt_sample_in  output  data_width  sample presented to the filter.
- filt_chan  output  chan_bits  delay-line bank select for the filter, held stable from issue through capture.
- filt_sample_out  input  data_width  filter result.
- out_valid  output  1  one-cycle strobe: out_data/out_chan valid.
- out_chan  output  chan_bits  channel of out_data.
- out_data  output  data_width  filtered sample.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (synchronous, active-high) clears:
  - state → IDLE, rr_ptr → 0, wait counter → 0.
  - Outputs: filt_enable, out_valid, busy → 0; filt_sample_in, filt_chan, out_chan, out_data → 0; in_ready → 0.
- States: IDLE, ISSUE, WAIT, CAPTURE.
- IDLE:
  - Grant = first channel i with in_valid[i]=1, searching from rr_ptr upward with wrap modulo num_channels.
  - in_ready is combinational and one-hot for the granted channel in this cycle only; a transfer occurs when in_valid[i] & in_ready[i].
  - On a grant, latch in_data slice and channel index; next state ISSUE.
  - With no in_valid, remain in IDLE with in_ready=0.
- ISSUE (1 cycle):
  - filt_enable=1, filt_sample_in=latched sample, filt_chan=latched channel.
  - Load counter with filter_latency; next state WAIT.
- WAIT:
  - filt_enable=0; filt_chan and filt_sample_in held.
  - Counter decrements each cycle; when it reaches 1, register filt_sample_out into out_data and the channel into out_chan on that edge; next state CAPTURE.
- CAPTURE (1 cycle):
  - out_valid=1.
  - rr_ptr ← latched channel+1, wrapping to 0 at num_channels.
  - Next state IDLE.
- Timing: accept at cycle T → filt_enable at T+1 → out_valid at T+2+filter_latency. Maximum throughput is one sample per filter_latency+3 cycles.
- in_ready is never high outside IDLE; senders must hold in_valid/in_data until accepted.
- in_valid dropping without a handshake is legal and grants nothing.
- Simultaneous requests: the channel at or after rr_ptr wins. The other channel is served next, so no channel waits more than num_channels transactions.
- Channel indices ≥ num_channels are never generated; rr_ptr wraps from num_channels-1 to 0.
- out_data is registered and holds its value between out_valid strobes.
- Reset mid-operation: the in-flight sample is discarded and no out_valid is produced. The filter bank contents are not this block's responsibility.
- No arithmetic on the data path; widths pass through unchanged.

Test Plan:
- Reset, idle: hold reset 2 cycles with in_valid=2'b11 → in_ready=0, out_valid=0, busy=0 during reset. After release, the first grant goes to ch0 (rr_ptr=0).
- Single transfer (filter_latency=1): ch0 valid, data 16'h1234, accepted at T; filter model returns input+1.
  - filt_enable=1 at T+1 with filt_sample_in=16'h1234, filt_chan=0.
  - out_valid=1 at T+3 with out_data=16'h1235, out_chan=0.
- Round-robin fairness: both channels held valid continuously (ch0=16'h0100, ch1=16'h0200) → grants alternate 0,1,0,1 over 4 transactions; grant spacing is exactly 4 cycles.
- Backpressure hold: ch1 raises valid while busy → in_ready[1] stays 0 until IDLE. ch1 data 16'hBEEF is accepted once and appears exactly once at out_data with out_chan=1.
- Latency parameter: filter_latency=3 → out_valid exactly 5 cycles after acceptance; filt_chan stable across all WAIT cycles.
- Reset mid-WAIT: assert reset during WAIT → no out_valid; state returns to IDLE. After release, the next request from ch1 is accepted and completes normally.
